// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - register array with valid/ready read port and response FIFO
// Optional RF_BYPASS_EN: a read that collides with a same-cycle write returns the new data.
module regfile_read_port #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_reg,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [ADDR_W-1:0] rd_resp_reg,
    output logic [DATA_W-1:0] rd_resp_data
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    logic [DATA_W-1:0] regs      [NREG];
    logic [DATA_W-1:0] fifo_data [BUF_DEPTH];
    logic [ADDR_W-1:0] fifo_reg  [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              req_ready_q;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] rd_sample;

    assign push = rd_req_valid && req_ready_q;
    assign pop  = (count != '0) && rd_resp_ready;

    always_comb begin
        rd_sample = regs[rd_req_reg];
`ifdef RF_BYPASS_EN
        if (write_en && (write_reg == rd_req_reg)) begin
            rd_sample = write_data;
        end
`endif
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // FIFO storage needs no reset: outputs are masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_data[wr_ptr] <= rd_sample;
            fifo_reg[wr_ptr]  <= rd_req_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_next;
            req_ready_q <= (count_next < DEPTH_C);
        end
    end

    assign rd_req_ready  = req_ready_q;
    assign rd_resp_valid = (count != '0);
    assign rd_resp_reg   = rd_resp_valid ? fifo_reg[rd_ptr]  : '0;
    assign rd_resp_data  = rd_resp_valid ? fifo_data[rd_ptr] : '0;
endmodule

// File: tb/tb_regfile_read_port.sv
// tb/tb_regfile_read_port.sv - self-checking bench for regfile_read_port
module tb_regfile_read_port;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int BUF_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              write_en = 1'b0;
    logic [ADDR_W-1:0] write_reg = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic              rd_req_valid = 1'b0;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_reg = '0;
    logic              rd_resp_valid;
    logic              rd_resp_ready = 1'b0;
    logic [ADDR_W-1:0] rd_resp_reg;
    logic [DATA_W-1:0] rd_resp_data;

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_reg(rd_req_reg),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_resp_reg(rd_resp_reg), .rd_resp_data(rd_resp_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents plus an in-order queue of expected responses.
    logic [DATA_W-1:0]        m_regs [1<<ADDR_W];
    logic [ADDR_W+DATA_W-1:0] m_q [$];
    logic                     m_ready = 1'b0;
    logic                     m_known = 1'b0;
    int                       n_pop = 0;

    // One clock: compare outputs against the model, advance the model, cross the edge.
    task automatic tick();
        logic [DATA_W-1:0] d;
        logic              acc;
        logic              pp;
        if (m_known) begin
            checks++;
            if (rd_req_ready !== m_ready) begin
                errors++;
                $display("FAIL ready: got %b expected %b at %0t", rd_req_ready, m_ready, $time);
            end
            checks++;
            if (rd_resp_valid !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL valid: got %b expected %b at %0t", rd_resp_valid, m_q.size() != 0, $time);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({rd_resp_reg, rd_resp_data} !== m_q[0]) begin
                    errors++;
                    $display("FAIL head: got reg %0d data %h expected reg %0d data %h at %0t",
                             rd_resp_reg, rd_resp_data, m_q[0][ADDR_W+DATA_W-1:DATA_W],
                             m_q[0][DATA_W-1:0], $time);
                end
            end else begin
                checks++;
                if (rd_resp_reg !== '0 || rd_resp_data !== '0) begin
                    errors++;
                    $display("FAIL idle_out: got reg %0d data %h expected 0", rd_resp_reg, rd_resp_data);
                end
            end
        end
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_q.delete();
            m_ready = 1'b0;
            m_known = 1'b1;
        end else begin
            acc = rd_req_valid && m_ready;
            pp  = rd_resp_ready && (m_q.size() != 0);
            if (pp) begin
                void'(m_q.pop_front());
                n_pop++;
            end
            if (acc) begin
                d = m_regs[rd_req_reg];
`ifdef RF_BYPASS_EN
                if (write_en && write_reg == rd_req_reg) d = write_data;
`endif
                m_q.push_back({rd_req_reg, d});
            end
            if (write_en) m_regs[write_reg] = write_data;
            m_ready = (m_q.size() < BUF_DEPTH);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        write_en = 1'b0; rd_req_valid = 1'b0; rd_resp_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_req_valid = 1'b0; write_en = 1'b0; rd_resp_ready = 1'b1;
        while (m_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (m_q.size() != 0 || rd_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: valid %b left %0d expected empty", rd_resp_valid, m_q.size());
        end
        rd_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        rd_req_valid = 1'b1;
        write_en = 1'b1; write_reg = 4'd5; write_data = 32'h1234;
        tick(); tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
        checks++;
        if (rd_req_ready !== 1'b1 || rd_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready %b valid %b expected 1 0", rd_req_ready, rd_resp_valid);
        end
        rd_req_valid = 1'b1; rd_req_reg = 4'd5;
        tick();
        rd_req_valid = 1'b0;
        checks++;
        if (rd_resp_valid !== 1'b1 || rd_resp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg5: valid %b data %h expected 1 00000000", rd_resp_valid, rd_resp_data);
        end
        drain();
    endtask

    task automatic test_write_read();
        write_en = 1'b1; write_reg = 4'd3; write_data = 32'hDEADBEEF;
        tick();
        write_en = 1'b0;
        rd_req_valid = 1'b1; rd_req_reg = 4'd3; rd_resp_ready = 1'b1;
        tick();
        rd_req_valid = 1'b0;
        checks++;
        if (rd_resp_valid !== 1'b1 || rd_resp_reg !== 4'd3 || rd_resp_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read: valid %b reg %0d data %h expected 1 3 deadbeef",
                     rd_resp_valid, rd_resp_reg, rd_resp_data);
        end
        drain();
    endtask

    task automatic test_backpressure();
        write_en = 1'b1; write_reg = 4'd1; write_data = 32'h11; tick();
        write_reg = 4'd2; write_data = 32'h22; tick();
        write_en = 1'b0; rd_resp_ready = 1'b0;
        rd_req_valid = 1'b1; rd_req_reg = 4'd1; tick();
        rd_req_reg = 4'd2; tick();
        checks++;
        if (rd_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b expected 0", rd_req_ready);
        end
        rd_req_reg = 4'd9; tick(); tick();   // refused while full
        rd_req_valid = 1'b0;
        checks++;
        if (rd_resp_data !== 32'h11) begin
            errors++;
            $display("FAIL stall_hold: got %h expected 00000011", rd_resp_data);
        end
        rd_resp_ready = 1'b1; tick();
        checks++;
        if (rd_resp_data !== 32'h22 || rd_resp_reg !== 4'd2) begin
            errors++;
            $display("FAIL second: reg %0d data %h expected 2 00000022", rd_resp_reg, rd_resp_data);
        end
        tick(); tick();
        checks++;
        if (rd_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_return: got %b expected 1", rd_req_ready);
        end
        drain();
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] exp;
        write_en = 1'b1; write_reg = 4'd7; write_data = 32'hA; tick();
        write_data = 32'hB; rd_req_valid = 1'b1; rd_req_reg = 4'd7; tick();
        write_en = 1'b0; rd_req_valid = 1'b0;
`ifdef RF_BYPASS_EN
        exp = 32'hB;
`else
        exp = 32'hA;
`endif
        checks++;
        if (rd_resp_data !== exp) begin
            errors++;
            $display("FAIL collision: got %h expected %h", rd_resp_data, exp);
        end
        drain();
        rd_req_valid = 1'b1; tick();
        rd_req_valid = 1'b0;
        checks++;
        if (rd_resp_data !== 32'hB) begin
            errors++;
            $display("FAIL after_collision: got %h expected 0000000b", rd_resp_data);
        end
        drain();
    endtask

    task automatic test_reset_full();
        rd_req_valid = 1'b1; rd_resp_ready = 1'b0;
        rd_req_reg = 4'd3; tick();
        rd_req_reg = 4'd7; tick();
        rst_n = 1'b0; rd_req_valid = 1'b0; tick();
        checks++;
        if (rd_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: valid %b expected 0", rd_resp_valid);
        end
        rst_n = 1'b1; tick();
        rd_resp_ready = 1'b1;
        for (int r = 0; r < 16; r++) begin
            rd_req_valid = 1'b1; rd_req_reg = ADDR_W'(r); tick();
            checks++;
            if (rd_resp_valid !== 1'b1 || rd_resp_data !== '0 || rd_resp_reg !== ADDR_W'(r)) begin
                errors++;
                $display("FAIL cleared_reg: valid %b reg %0d data %h expected 1 %0d 0",
                         rd_resp_valid, rd_resp_reg, rd_resp_data, r);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int p0;
        for (int r = 0; r < 8; r++) begin
            write_en = 1'b1; write_reg = ADDR_W'(r); write_data = $urandom; tick();
        end
        write_en = 1'b0; rd_resp_ready = 1'b1;
        p0 = n_pop;
        for (int r = 0; r < 8; r++) begin
            rd_req_valid = 1'b1; rd_req_reg = ADDR_W'(r); tick();
            checks++;
            if (rd_resp_valid !== 1'b1 || rd_resp_reg !== ADDR_W'(r)) begin
                errors++;
                $display("FAIL stream: valid %b reg %0d expected 1 %0d", rd_resp_valid, rd_resp_reg, r);
            end
        end
        rd_req_valid = 1'b0; tick();
        checks++;
        if (n_pop - p0 != 8) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 8", n_pop - p0);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            write_en      = ($urandom_range(0, 2) == 0);
            write_reg     = ADDR_W'($urandom_range(0, 15));
            write_data    = $urandom;
            rd_req_valid  = ($urandom_range(0, 1) == 1);
            rd_req_reg    = ($urandom_range(0, 3) == 0) ? write_reg : ADDR_W'($urandom_range(0, 15));
            rd_resp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_backpressure();
        test_collision();
        test_reset_full();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
